fuzzy_sweep_driver: RTL and testbench

FUZZY_SWEEP_DRIVER -- requirements
Module: fuzzy_sweep_driver

---
 rtl/fuzzy_sweep_driver.sv | 121 ++++++++++++
 tb/tb_fuzzy_sweep_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fuzzy_sweep_driver.sv
// Sweeps a two-input controller over every (i, j) code pair, waits for its output to settle,
// and hands each sampled result downstream over a valid/ready handshake.
module fuzzy_sweep_driver #(
  parameter int unsigned SETTLE_CYCLES = 33,
  parameter int unsigned CODE_MIN      = 1,
  parameter int unsigned CODE_MAX      = 254
) (
  input  logic        clk_0,
  input  logic        Srst,
  input  logic        start,
  input  logic [7:0]  saida_defuzzy,
  output logic [7:0]  Entrada_01,
  output logic [7:0]  Entrada_02,
  output logic [23:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0]  CodeMin    = 8'(CODE_MIN);
  localparam logic [7:0]  CodeMax    = 8'(CODE_MAX);
  localparam logic [15:0] SettleLoad = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StHold, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  i_q, i_d, j_q, j_d;
  logic [7:0]  e1_q, e1_d, e2_q, e2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [23:0] data_q, data_d;
  logic        valid_q, valid_d;

  function automatic logic [7:0] clamp(input logic [7:0] v);
    if (v < CodeMin) return CodeMin;
    if (v > CodeMax) return CodeMax;
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    e1_d    = e1_q;
    e2_d    = e2_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          cnt_d   = SettleLoad;
          e1_d    = clamp(8'd0);
          e2_d    = clamp(8'd0);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          data_d  = {i_q, j_q, saida_defuzzy};
          valid_d = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StHold: begin
        if (valid_q && res_ready) begin
          valid_d = 1'b0;
          if (i_q == CodeMax && j_q == CodeMax) begin
            state_d = StDone;
          end else begin
            // j is the inner index; it wraps to 0 and carries into i at the row end
            if (j_q == CodeMax) begin
              j_d = '0;
              i_d = i_q + 8'd1;
            end else begin
              j_d = j_q + 8'd1;
            end
            e1_d    = clamp(i_d);
            e2_d    = clamp(j_d);
            cnt_d   = SettleLoad;
            state_d = StSettle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_0 or posedge Srst) begin
    if (Srst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      e1_q    <= CodeMin;
      e2_q    <= CodeMin;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Entrada_01 = e1_q;
  assign Entrada_02 = e2_q;
  assign res_data   = data_q;
  assign res_valid  = valid_q;
  assign busy       = (state_q == StSettle) || (state_q == StHold);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_fuzzy_sweep_driver.sv
// Bench for fuzzy_sweep_driver: a default-range instance with short settling for timing, wrap
// and reset cases, and a tiny-range instance swept end to end against a plant model.
module tb_fuzzy_sweep_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_a, rr_a, rv_a, busy_a, done_a;
  logic [7:0]  y_a, e1_a, e2_a;
  logic [23:0] rd_a;
  logic        start_b, rr_b, rv_b, busy_b, done_b;
  logic [7:0]  y_b, e1_b, e2_b;
  logic [8:0]  sum_b;
  logic [23:0] rd_b;

  // plant models for the controller under test
  assign y_a   = e1_a + {e2_a[6:0], 1'b0};
  assign sum_b = {1'b0, e1_b} + {1'b0, e2_b};
  assign y_b   = sum_b[8:1];

  fuzzy_sweep_driver #(.SETTLE_CYCLES(4), .CODE_MIN(1), .CODE_MAX(254)) dut_a (
    .clk_0(clk), .Srst(rst), .start(start_a), .saida_defuzzy(y_a),
    .Entrada_01(e1_a), .Entrada_02(e2_a), .res_data(rd_a), .res_valid(rv_a),
    .res_ready(rr_a), .busy(busy_a), .done(done_a)
  );

  fuzzy_sweep_driver #(.SETTLE_CYCLES(1), .CODE_MIN(2), .CODE_MAX(5)) dut_b (
    .clk_0(clk), .Srst(rst), .start(start_b), .saida_defuzzy(y_b),
    .Entrada_01(e1_b), .Entrada_02(e2_b), .res_data(rd_b), .res_valid(rv_b),
    .res_ready(rr_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cl(input int v, input int lo, input int hi);
    return 8'(v < lo ? lo : (v > hi ? hi : v));
  endfunction

  function automatic logic [23:0] exp_a(input int i, input int j);
    int y;
    y = (int'(cl(i, 1, 254)) + 2 * int'(cl(j, 1, 254))) % 256;
    return {8'(i), 8'(j), 8'(y)};
  endfunction

  function automatic logic [23:0] exp_b(input int i, input int j);
    int y;
    y = (int'(cl(i, 2, 5)) + int'(cl(j, 2, 5))) / 2;
    return {8'(i), 8'(j), 8'(y)};
  endfunction

  // waits (bounded) for res_valid on instance A; n counts negedges waited
  task automatic get_point(output logic [23:0] d, output logic [7:0] x1, output logic [7:0] x2,
                           output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rv_a !== 1'b1 && n < 64);
    d  = rd_a;
    x1 = e1_a;
    x2 = e2_a;
  endtask

  typedef struct {
    int         i;
    int         j;
    logic [7:0] e1;
    logic [7:0] e2;
    logic [7:0] y;
  } vec_t;

  vec_t        vec[8];
  logic [23:0] d;
  logic [7:0]  x1, x2;
  int          n, bi, bj, nb, cyc, guard;
  bit          hit, alive;

  initial begin
    vec[0] = '{0,   3, 8'd1,  8'd3,   8'h07};
    vec[1] = '{0, 254, 8'd1,  8'd254, 8'hFD};
    vec[2] = '{1,   0, 8'd1,  8'd1,   8'h03};
    vec[3] = '{1,   1, 8'd1,  8'd1,   8'h03};
    vec[4] = '{3, 254, 8'd3,  8'd254, 8'hFF};
    vec[5] = '{4,   0, 8'd4,  8'd1,   8'h06};
    vec[6] = '{4,   5, 8'd4,  8'd5,   8'h0E};
    vec[7] = '{10, 19, 8'd10, 8'd19,  8'h30};

    rst = 1'b1; start_a = 1'b0; rr_a = 1'b0; start_b = 1'b0; rr_b = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_ent", 32'({e1_a, e2_a}), 32'h0101);
    check("rst_a_data", 32'(rd_a), 0);
    check("rst_a_flags", 32'({rv_a, busy_a, done_a}), 0);
    check("rst_b_ent", 32'({e1_b, e2_b}), 32'h0202);

    rst = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("a_start_ent", 32'({e1_a, e2_a}), 32'h0101);
    check("a_start_busy", 32'({busy_a, rv_a}), 32'h2);
    get_point(d, x1, x2, n);
    check("a_latency", 32'(n), 4);
    check("a_first_data", 32'(d), 32'h000003);

    // backpressure: result and drive must stay frozen
    repeat (10) begin
      @(negedge clk);
      check("a_bp_data", 32'(rd_a), 32'h000003);
      check("a_bp_ent", 32'({rv_a, e1_a, e2_a}), 32'h10101);
    end
    rr_a = 1'b1;
    @(negedge clk);
    check("a_bp_xfer", 32'(rv_a), 0);
    check("a_j1_ent", 32'({e1_a, e2_a}), 32'h0101);
    get_point(d, x1, x2, n);
    check("a_j1_latency", 32'(n), 4);
    check("a_j1_data", 32'(d), 32'h000103);

    // start during SETTLE must not disturb indices or timing
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    get_point(d, x1, x2, n);
    check("a_ss_latency", 32'(n), 3);
    check("a_ss_data", 32'(d), 32'h000205);
    check("a_ss_ent", 32'({x1, x2}), 32'h0102);

    bi = 0; bj = 3; alive = 1'b1; guard = 0;
    for (int k = 0; k < 8 && alive; k++) begin
      hit = 1'b0;
      while (!hit && alive) begin
        get_point(d, x1, x2, n);
        guard++;
        if (rv_a !== 1'b1 || guard > 3000) begin
          alive = 1'b0;
          check("a_stream_timeout", 32'(rv_a), 1);
        end
        hit = (bi == vec[k].i) && (bj == vec[k].j);
        if (hit) begin
          check("vec_data", 32'(d), 32'({8'(bi), 8'(bj), vec[k].y}));
          check("vec_ent", 32'({x1, x2}), 32'({vec[k].e1, vec[k].e2}));
        end else begin
          check("stream_data", 32'(d), 32'(exp_a(bi, bj)));
        end
        if (bj == 254) begin
          bj = 0;
          bi++;
        end else begin
          bj++;
        end
      end
    end

    // hold (10,20), then reset asynchronously mid-HOLD
    get_point(d, x1, x2, n);
    rr_a = 1'b0;
    check("a_1020_data", 32'(d), 32'h0A1432);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("a_arst_ent", 32'({e1_a, e2_a}), 32'h0101);
    check("a_arst_data", 32'(rd_a), 0);
    check("a_arst_flags", 32'({rv_a, busy_a, done_a}), 0);
    @(negedge clk);
    rst = 1'b0;
    rr_a = 1'b1;
    @(negedge clk);
    check("a_post_rst_valid", 32'(rv_a), 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    get_point(d, x1, x2, n);
    check("a_restart_latency", 32'(n), 4);
    check("a_restart_data", 32'(d), 32'h000003);

    // full sweep on the small instance, res_ready toggling
    bi = 0; bj = 0; nb = 0; cyc = 0;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_start_ent", 32'({e1_b, e2_b}), 32'h0202);
    while (done_b !== 1'b1 && cyc < 2000) begin
      cyc++;
      rr_b = (cyc % 3) != 0;
      if (rv_b === 1'b1 && rr_b) begin
        check("b_point_data", 32'(rd_b), 32'(exp_b(bi, bj)));
        check("b_point_ent", 32'({e1_b, e2_b}), 32'({cl(bi, 2, 5), cl(bj, 2, 5)}));
        nb++;
        if (bj == 5) begin
          bj = 0;
          bi++;
        end else begin
          bj++;
        end
      end
      @(negedge clk);
    end
    check("b_count", 32'(nb), 36);
    check("b_done_flags", 32'({done_b, busy_b, rv_b}), 32'h4);
    check("b_last_data", 32'(rd_b), 32'h050505);
    check("b_done_ent", 32'({e1_b, e2_b}), 32'h0505);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_restart_flags", 32'({done_b, busy_b}), 32'h1);
    check("b_restart_ent", 32'({e1_b, e2_b}), 32'h0202);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
